// File: rtl/scariv_fetch_inst_queue_if.sv
// Fetch->decode line interface: frontend pushes 128-bit lines, dispatch pulls instruction groups.
interface scariv_fetch_inst_queue_if #(
  parameter int LINE_W    = 128,
  parameter int DISP_SIZE = 2,
  parameter int VADDR_W   = 39
);
  localparam int SLOT_W = $clog2(LINE_W / 32);
  localparam int DCNT_W = $clog2(DISP_SIZE + 1);

  logic                        flush;
  logic                        f_valid;
  logic                        f_ready;
  logic [VADDR_W-1:0]          f_pc;
  logic [SLOT_W-1:0]           f_start;
  logic [LINE_W-1:0]           f_data;
  logic                        d_valid;
  logic [DCNT_W-1:0]           d_count;
  logic [DISP_SIZE*32-1:0]     d_inst;
  logic [DISP_SIZE*VADDR_W-1:0] d_pc;
  logic                        d_ready;

  modport master (
    output flush, f_valid, f_pc, f_start, f_data, d_ready,
    input  f_ready, d_valid, d_count, d_inst, d_pc
  );

  modport slave (
    input  flush, f_valid, f_pc, f_start, f_data, d_ready,
    output f_ready, d_valid, d_count, d_inst, d_pc
  );
endinterface

// File: rtl/scariv_fetch_inst_queue.sv
// Fetch instruction queue: buffers whole fetch lines and hands out up to DISP_SIZE insts per cycle
// in program order, splitting lines and spanning line boundaries.
module scariv_fetch_inst_queue #(
  parameter int LINE_W    = 128,
  parameter int DEPTH     = 6,
  parameter int DISP_SIZE = 2,
  parameter int VADDR_W   = 39
) (
  input logic                     i_clk,
  input logic                     i_reset,
  scariv_fetch_inst_queue_if.slave fq
);
  localparam int INST_PER_LINE = LINE_W / 32;
  localparam int SLOT_W        = $clog2(INST_PER_LINE);
  localparam int PTR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W         = $clog2(DEPTH + 1);
  localparam int DCNT_W        = $clog2(DISP_SIZE + 1);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [VADDR_W-1:0] pc_mem    [DEPTH];
  logic [LINE_W-1:0]  data_mem  [DEPTH];
  logic [SLOT_W-1:0]  start_mem [DEPTH];

  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [CNT_W-1:0]  count;
  logic [SLOT_W-1:0] head_slot;

  logic                         push;
  logic                         pop;
  logic [PTR_W-1:0]             walk_ptr;
  logic [SLOT_W-1:0]            walk_slot;
  logic [CNT_W-1:0]             walk_left;
  logic [CNT_W-1:0]             walk_freed;
  logic [DCNT_W-1:0]            walk_n;
  logic [DISP_SIZE*32-1:0]      lane_inst;
  logic [DISP_SIZE*VADDR_W-1:0] lane_pc;
  logic [CNT_W-1:0]             base_left;

  // Walk forward from the head slot, one lane per inst; the walker's end position is the new head.
  always_comb begin
    walk_ptr   = head_ptr;
    walk_slot  = head_slot;
    walk_left  = count;
    walk_freed = '0;
    walk_n     = '0;
    lane_inst  = '0;
    lane_pc    = '0;
    for (int j = 0; j < DISP_SIZE; j++) begin
      if (walk_left != '0) begin
        lane_inst[j*32 +: 32]           = data_mem[walk_ptr][32*int'(walk_slot) +: 32];
        lane_pc[j*VADDR_W +: VADDR_W]   = pc_mem[walk_ptr] + VADDR_W'({walk_slot, 2'b00});
        walk_n = walk_n + 1'b1;
        if (walk_slot == SLOT_W'(INST_PER_LINE - 1)) begin
          walk_ptr   = next_ptr(walk_ptr);
          walk_left  = walk_left - 1'b1;
          walk_freed = walk_freed + 1'b1;
          walk_slot  = start_mem[walk_ptr];
        end else begin
          walk_slot = walk_slot + 1'b1;
        end
      end
    end
  end

  assign fq.f_ready = (count < CNT_W'(DEPTH));
  assign fq.d_valid = (count != '0);
  assign fq.d_count = walk_n;
  assign fq.d_inst  = lane_inst;
  assign fq.d_pc    = lane_pc;

  assign push      = fq.f_valid && fq.f_ready;
  assign pop       = fq.d_valid && fq.d_ready;
  assign base_left = count - (pop ? walk_freed : '0);

  // When the queue drains completely, the head slot comes from the line being pushed (if any).
  always_ff @(posedge i_clk) begin
    if (i_reset || fq.flush) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      count     <= '0;
      head_slot <= '0;
    end else begin
      if (push) tail_ptr <= next_ptr(tail_ptr);
      if (pop)  head_ptr <= walk_ptr;
      count <= base_left + CNT_W'(push);
      if (base_left == '0) begin
        head_slot <= push ? fq.f_start : '0;
      end else if (pop) begin
        head_slot <= walk_slot;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !fq.flush && !i_reset) begin
      pc_mem[tail_ptr]    <= fq.f_pc;
      data_mem[tail_ptr]  <= fq.f_data;
      start_mem[tail_ptr] <= fq.f_start;
    end
  end

  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_reset)
    (count == CNT_W'(DEPTH)) |-> !push);
  a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset)
    count <= CNT_W'(DEPTH));
  a_pc_aligned: assert property (@(posedge i_clk) disable iff (i_reset)
    push |-> (fq.f_pc[SLOT_W+1:0] == '0));
endmodule

// File: tb/tb_scariv_fetch_inst_queue.sv
// Bench for scariv_fetch_inst_queue: vector table, directed corner sequences and a randomized run
// against an instruction-level FIFO reference model.
module tb_scariv_fetch_inst_queue;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scariv_fetch_inst_queue_if #(.LINE_W(128), .DISP_SIZE(2), .VADDR_W(39)) fq ();

  scariv_fetch_inst_queue #(.LINE_W(128), .DEPTH(DEPTH), .DISP_SIZE(2), .VADDR_W(39)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .fq      (fq.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] inst;
    logic [38:0] pc;
  } ent_t;
  ent_t mq[$];
  int   ml[$];

  logic        obs_rdy;
  logic        obs_vld;
  logic [1:0]  obs_cnt;
  logic [63:0] obs_inst;
  logic [77:0] obs_pc;

  typedef struct {
    bit          rst;
    bit          fv;
    logic [38:0] pc;
    logic [1:0]  st;
    bit          rdy;
    bit          e_rdy;
    int          e_cnt;
    logic [38:0] e_p0;
    logic [38:0] e_p1;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mk_inst(input logic [38:0] pc);
    return {4'hC, pc[27:0]};
  endfunction

  function automatic logic [127:0] mk_line(input logic [38:0] pc);
    logic [127:0] ln;
    for (int k = 0; k < 4; k++) ln[32*k +: 32] = mk_inst(pc + 39'(4 * k));
    return ln;
  endfunction

  function automatic vec_t mv(input bit r, input bit fv, input logic [38:0] pc, input logic [1:0] st,
                              input bit rdy, input bit e_rdy, input int e_cnt,
                              input logic [38:0] e_p0, input logic [38:0] e_p1);
    vec_t v;
    v.rst = r; v.fv = fv; v.pc = pc; v.st = st; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_p0 = e_p0; v.e_p1 = e_p1;
    return v;
  endfunction

  task automatic drv(input bit v, input logic [38:0] pc, input logic [1:0] st, input bit rdy);
    fq.f_valid = v;
    fq.f_pc    = pc;
    fq.f_start = st;
    fq.f_data  = mk_line(pc);
    fq.d_ready = rdy;
  endtask

  task automatic cmp_model();
    int n;
    n = (mq.size() < 2) ? mq.size() : 2;
    chk("m_f_ready", 64'(obs_rdy), 64'(ml.size() < DEPTH));
    chk("m_d_valid", 64'(obs_vld), 64'(n != 0));
    chk("m_d_count", 64'(obs_cnt), 64'(n));
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("m_inst%0d", j), 64'(obs_inst[j*32 +: 32]), (j < n) ? 64'(mq[j].inst) : 64'd0);
      chk($sformatf("m_pc%0d", j), 64'(obs_pc[j*39 +: 39]), (j < n) ? 64'(mq[j].pc) : 64'd0);
    end
  endtask

  task automatic model_update();
    int pre_lines;
    int n;
    if (rst || fq.flush) begin
      mq.delete();
      ml.delete();
      return;
    end
    pre_lines = ml.size();
    if (fq.d_ready && mq.size() > 0) begin
      n = (mq.size() < 2) ? mq.size() : 2;
      for (int k = 0; k < n; k++) begin
        void'(mq.pop_front());
        ml[0] = ml[0] - 1;
        if (ml[0] == 0) void'(ml.pop_front());
      end
    end
    if (fq.f_valid && pre_lines < DEPTH) begin
      for (int k = int'(fq.f_start); k < 4; k++) begin
        ent_t e;
        e.inst = fq.f_data[32*k +: 32];
        e.pc   = fq.f_pc + 39'(4 * k);
        mq.push_back(e);
      end
      ml.push_back(4 - int'(fq.f_start));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    obs_rdy  = fq.f_ready;
    obs_vld  = fq.d_valid;
    obs_cnt  = fq.d_count;
    obs_inst = fq.d_inst;
    obs_pc   = fq.d_pc;
    cmp_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq.flush = 1'b0;
    drv(0, '0, 2'd0, 0);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int          got;
    bit          sent;
    logic [38:0] nxt;
    logic [63:0] r64;

    tbl[0]  = mv(1, 0, 39'h0,    0, 0, 1, 0, 39'h0,    39'h0);
    tbl[1]  = mv(0, 1, 39'h1000, 0, 1, 1, 0, 39'h0,    39'h0);
    tbl[2]  = mv(0, 0, 39'h0,    0, 1, 1, 2, 39'h1000, 39'h1004);
    tbl[3]  = mv(0, 0, 39'h0,    0, 1, 1, 2, 39'h1008, 39'h100C);
    tbl[4]  = mv(0, 0, 39'h0,    0, 0, 1, 0, 39'h0,    39'h0);
    tbl[5]  = mv(0, 1, 39'h2000, 3, 0, 1, 0, 39'h0,    39'h0);
    tbl[6]  = mv(0, 1, 39'h2010, 0, 0, 1, 1, 39'h200C, 39'h0);
    tbl[7]  = mv(0, 0, 39'h0,    0, 0, 1, 2, 39'h200C, 39'h2010);
    tbl[8]  = mv(0, 0, 39'h0,    0, 0, 1, 2, 39'h200C, 39'h2010);
    tbl[9]  = mv(0, 0, 39'h0,    0, 1, 1, 2, 39'h200C, 39'h2010);
    tbl[10] = mv(0, 0, 39'h0,    0, 1, 1, 2, 39'h2014, 39'h2018);
    tbl[11] = mv(0, 0, 39'h0,    0, 1, 1, 1, 39'h201C, 39'h0);
    tbl[12] = mv(0, 0, 39'h0,    0, 0, 1, 0, 39'h0,    39'h0);

    fq.flush = 1'b0;
    drv(0, '0, 2'd0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Line split / line spanning vectors
    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      drv(tbl[i].fv, tbl[i].pc, tbl[i].st, tbl[i].rdy);
      cycle();
      chk($sformatf("t%0d_f_ready", i), 64'(obs_rdy), 64'(tbl[i].e_rdy));
      chk($sformatf("t%0d_count", i), 64'(obs_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("t%0d_pc0", i), 64'(obs_pc[38:0]), 64'(tbl[i].e_p0));
      chk($sformatf("t%0d_pc1", i), 64'(obs_pc[77:39]), 64'(tbl[i].e_p1));
      chk($sformatf("t%0d_inst0", i), 64'(obs_inst[31:0]),
          (tbl[i].e_cnt > 0) ? 64'(mk_inst(tbl[i].e_p0)) : 64'd0);
      chk($sformatf("t%0d_inst1", i), 64'(obs_inst[63:32]),
          (tbl[i].e_cnt > 1) ? 64'(mk_inst(tbl[i].e_p1)) : 64'd0);
    end
    rst = 1'b0;

    // Fill to full, stall a 7th line, then drain everything in order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv(1, 39'h4000 + 39'(16 * i), 2'd0, 0);
      cycle();
    end
    drv(1, 39'h4060, 2'd0, 0);
    cycle();
    chk("t3_full", 64'(obs_rdy), 64'd0);
    cycle();
    chk("t3_stall", 64'(obs_rdy), 64'd0);
    sent = 0;
    got  = 0;
    nxt  = 39'h4000;
    for (int c = 0; c < 40 && got < 28; c++) begin
      drv(!sent, 39'h4060, 2'd0, 1);
      cycle();
      if (obs_vld) begin
        for (int j = 0; j < int'(obs_cnt); j++) begin
          chk("t3_order", 64'(obs_pc[j*39 +: 39]), 64'(nxt));
          nxt = nxt + 39'd4;
          got++;
        end
      end
      if (!sent && obs_rdy) sent = 1;
    end
    chk("t3_total", 64'(got), 64'd28);

    // Push and pop in the same cycle at count 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(1, 39'h6000 + 39'(16 * i), 2'd0, 0);
      cycle();
    end
    drv(0, '0, 2'd0, 1);
    cycle();
    drv(1, 39'h6050, 2'd0, 1);
    cycle();
    chk("t4_pp_ready", 64'(obs_rdy), 64'd1);
    drv(1, 39'h6060, 2'd0, 0);
    cycle();
    chk("t4_ready5", 64'(obs_rdy), 64'd1);
    drv(0, '0, 2'd0, 0);
    cycle();
    chk("t4_full", 64'(obs_rdy), 64'd0);
    drv(0, '0, 2'd0, 1);
    repeat (14) cycle();

    // Flush beats a same-cycle push and pop
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1, 39'h7000 + 39'(16 * i), 2'd0, 0);
      cycle();
    end
    fq.flush = 1'b1;
    drv(1, 39'h5000, 2'd0, 1);
    cycle();
    fq.flush = 1'b0;
    drv(1, 39'h3000, 2'd1, 0);
    cycle();
    chk("t5_valid", 64'(obs_vld), 64'd0);
    chk("t5_count", 64'(obs_cnt), 64'd0);
    chk("t5_ready", 64'(obs_rdy), 64'd1);
    drv(0, '0, 2'd0, 0);
    cycle();
    chk("t5_count2", 64'(obs_cnt), 64'd2);
    chk("t5_pc0", 64'(obs_pc[38:0]), 64'h3004);
    chk("t5_inst0", 64'(obs_inst[31:0]), 64'(mk_inst(39'h3004)));

    // Reset mid-operation wins over flush, push and pop
    for (int i = 0; i < 4; i++) begin
      drv(1, 39'h8000 + 39'(16 * i), 2'd0, 0);
      cycle();
    end
    rst = 1'b1;
    fq.flush = 1'b1;
    drv(1, 39'h9000, 2'd0, 1);
    cycle();
    rst = 1'b0;
    fq.flush = 1'b0;
    drv(0, '0, 2'd0, 0);
    cycle();
    chk("t6_ready", 64'(obs_rdy), 64'd1);
    chk("t6_valid", 64'(obs_vld), 64'd0);
    chk("t6_count", 64'(obs_cnt), 64'd0);
    chk("t6_inst", obs_inst, 64'd0);
    chk("t6_pc", 64'(obs_pc[63:0]), 64'd0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 10000; c++) begin
      int r;
      r   = int'($urandom_range(0, 999));
      rst = (r < 5);
      fq.flush   = (r >= 5 && r < 20);
      r64        = {$urandom(), $urandom()};
      fq.f_valid = ($urandom_range(0, 99) < 60);
      fq.f_pc    = {r64[38:4], 4'h0};
      fq.f_start = 2'($urandom_range(0, 3));
      fq.f_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      fq.d_ready = ($urandom_range(0, 99) < 55);
      cycle();
    end
    rst = 1'b0;
    fq.flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
